// File: rtl/mmcm_drp_ctrl.sv
// DRP read-modify-write initiator for MMCME2_ADV run-time retuning: hold MMCM in reset,
// RMW each register, release reset, wait for LOCKED. Define DRP_READBACK_EN to verify each write.
module mmcm_drp_ctrl #(
    parameter int RST_HOLD     = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_addr,
    input  logic [15:0] req_data,
    input  logic [15:0] req_keep,
    input  logic        req_last,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked
);

    localparam int CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT)
                           ? ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD)
                           : ((DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST,
        ST_RD,
        ST_RD_W,
        ST_WR,
        ST_WR_W,
        ST_HOLD,
        ST_LOCK,
        ST_DONE
`ifdef DRP_READBACK_EN
        , ST_VF,
        ST_VF_W
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [6:0]       addr_q;
    logic [15:0]      data_q, keep_q, new_q;
    logic             last_q;
    logic             den_raw, dwe_raw;
    logic             accept;

    assign accept    = req_valid && req_ready;
    assign err       = err_q;
    assign drp_daddr = addr_q;
    assign drp_di    = new_q;
    // DEN/DWE are gated so no access can be issued while reset is being sampled.
    assign drp_den   = den_raw && reset_n;
    assign drp_dwe   = dwe_raw && reset_n;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q <= '0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            new_q  <= '0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                data_q <= req_data;
                keep_q <= req_keep;
                last_q <= req_last;
            end
            if (state_q == ST_RD_W && drp_drdy)
                new_q <= (drp_do & keep_q) | (data_q & ~keep_q);
        end
    end

    // Outputs are a pure function of state, so a timeout shows err and released reset together.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        den_raw   = 1'b0;
        dwe_raw   = 1'b0;
        mmcm_rst  = 1'b1;
        case (state_q)
            ST_IDLE: begin req_ready = 1'b1; busy = 1'b0; mmcm_rst = 1'b0; end
            ST_HOLD: req_ready = 1'b1;
            ST_RD:   den_raw = 1'b1;
            ST_WR:   begin den_raw = 1'b1; dwe_raw = 1'b1; end
`ifdef DRP_READBACK_EN
            ST_VF:   den_raw = 1'b1;
`endif
            ST_LOCK: mmcm_rst = 1'b0;
            ST_DONE: begin done = 1'b1; busy = 1'b0; mmcm_rst = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_RD;
                else                   cnt_d   = cnt_q + CNT_ONE;
            end
            // The DEN cycle is counted as cycle 0 of the DRDY window.
            ST_RD: begin
                state_d = ST_RD_W;
                cnt_d   = CNT_ONE;
            end
            ST_RD_W: begin
                if (drp_drdy)               state_d = ST_WR;
                else if (cnt_q == DRDY_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else                    cnt_d = cnt_q + CNT_ONE;
            end
            ST_WR: begin
                state_d = ST_WR_W;
                cnt_d   = CNT_ONE;
            end
            ST_WR_W: begin
                if (drp_drdy) begin
`ifdef DRP_READBACK_EN
                    state_d = ST_VF;
`else
                    if (last_q) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_HOLD;
                    end
`endif
                end else if (cnt_q == DRDY_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef DRP_READBACK_EN
            ST_VF: begin
                state_d = ST_VF_W;
                cnt_d   = CNT_ONE;
            end
            ST_VF_W: begin
                if (drp_drdy) begin
                    if (drp_do != new_q) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (last_q) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else if (cnt_q == DRDY_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            ST_HOLD: begin
                if (accept) state_d = ST_RD;
            end
            ST_LOCK: begin
                if (mmcm_locked)            state_d = ST_DONE;
                else if (cnt_q == LOCK_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else                    cnt_d = cnt_q + CNT_ONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
